// File: rtl/drone_pkg.sv
// Shared definitions for the drone simulator input path: axis codes,
// axis FSM states and the request decoder used by both axes.
package drone_pkg;

  localparam logic [1:0] CODIGO_PARADO   = 2'b00;
  localparam logic [1:0] CODIGO_POSITIVO = 2'b01;
  localparam logic [1:0] CODIGO_NEGATIVO = 2'b10;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    ATIVO  = 2'b01,
    PAUSA  = 2'b10
  } estado_t;

  // Opposing presses cancel out to idle.
  function automatic logic [1:0] codigo_pedido(input logic positivo, input logic negativo);
    logic [1:0] codigo;
    case ({negativo, positivo})
      2'b01:   codigo = CODIGO_POSITIVO;
      2'b10:   codigo = CODIGO_NEGATIVO;
      default: codigo = CODIGO_PARADO;
    endcase
    return codigo;
  endfunction

endpackage

// File: rtl/controle_drone_entrada_filtro.sv
// filtro_botao: two-flop synchroniser followed by a debounce filter whose
// level flips only after the synchronised input disagrees for DEBOUNCE+1 edges.
module filtro_botao #(
  parameter int DEBOUNCE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic botao_i,
  output logic filtrado_o
);

  localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

  logic          sinc1_q, sinc2_q;
  logic          filtrado_q, filtrado_d;
  logic [CW-1:0] cont_q, cont_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc1_q    <= 1'b0;
      sinc2_q    <= 1'b0;
      filtrado_q <= 1'b0;
      cont_q     <= '0;
    end else begin
      sinc1_q    <= botao_i;
      sinc2_q    <= sinc1_q;
      filtrado_q <= filtrado_d;
      cont_q     <= cont_d;
    end
  end

  // Any agreement between input and filtered level restarts the count.
  always_comb begin
    filtrado_d = filtrado_q;
    cont_d     = '0;
    if (sinc2_q != filtrado_q) begin
      if (cont_q == CW'(DEBOUNCE)) begin
        filtrado_d = sinc2_q;
      end else begin
        cont_d = cont_q + 1'b1;
      end
    end
  end

  assign filtrado_o = filtrado_q;

endmodule

// File: rtl/controle_drone_entrada.sv
// Drone input front end: debounced buttons feed two auto-repeating axis FSMs
// (vertical, horizontal) plus a registered confirm level.
module controle_drone_entrada #(
  parameter int DEBOUNCE = 4,
  parameter int REPETE   = 200,
  parameter int PAUSA    = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       botao_cima,
  input  logic       botao_baixo,
  input  logic       botao_frente,
  input  logic       botao_tras,
  input  logic       botao_confirma,
  output logic [1:0] controle_vertical,
  output logic [1:0] controle_horizontal,
  output logic       confirma,
  output logic [3:0] db_estado
);

  localparam int MAXC = (REPETE > PAUSA) ? REPETE : PAUSA;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  // Bit order: cima, baixo, frente, tras, confirma.
  logic [4:0]      botoes;
  logic [4:0]      filtrado;
  logic [1:0][1:0] saida_w;
  logic [1:0][1:0] estado_w;
  logic            confirma_q;

  assign botoes = {botao_confirma, botao_tras, botao_frente, botao_baixo, botao_cima};

  for (genvar b = 0; b < 5; b++) begin : g_filtro
    filtro_botao #(.DEBOUNCE(DEBOUNCE)) u_filtro (
      .clock     (clock),
      .reset     (reset),
      .botao_i   (botoes[b]),
      .filtrado_o(filtrado[b])
    );
  end

  // g = 0 is the vertical axis (cima/baixo), g = 1 the horizontal (frente/tras).
  for (genvar g = 0; g < 2; g++) begin : g_eixo
    logic [1:0]         pedido;
    drone_pkg::estado_t estado_q, estado_d;
    logic [1:0]         codigo_q, codigo_d;
    logic [CW-1:0]      cont_q, cont_d;

    assign pedido = drone_pkg::codigo_pedido(filtrado[2*g], filtrado[2*g+1]);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        estado_q <= drone_pkg::OCIOSO;
        codigo_q <= drone_pkg::CODIGO_PARADO;
        cont_q   <= '0;
      end else begin
        estado_q <= estado_d;
        codigo_q <= codigo_d;
        cont_q   <= cont_d;
      end
    end

    always_comb begin
      estado_d = estado_q;
      codigo_d = codigo_q;
      cont_d   = cont_q;
      case (estado_q)
        drone_pkg::OCIOSO: begin
          if (pedido != drone_pkg::CODIGO_PARADO) begin
            estado_d = drone_pkg::ATIVO;
            codigo_d = pedido;
            cont_d   = '0;
          end
        end
        drone_pkg::ATIVO: begin
          // A direction swap restarts the repeat period without an idle cycle.
          if (pedido == drone_pkg::CODIGO_PARADO) begin
            estado_d = drone_pkg::OCIOSO;
            cont_d   = '0;
          end else if (pedido != codigo_q) begin
            codigo_d = pedido;
            cont_d   = '0;
          end else if (cont_q == CW'(REPETE - 1)) begin
            estado_d = drone_pkg::PAUSA;
            cont_d   = '0;
          end else begin
            cont_d = cont_q + 1'b1;
          end
        end
        drone_pkg::PAUSA: begin
          if (pedido == drone_pkg::CODIGO_PARADO) begin
            estado_d = drone_pkg::OCIOSO;
            cont_d   = '0;
          end else if (cont_q == CW'(PAUSA - 1)) begin
            estado_d = drone_pkg::ATIVO;
            codigo_d = pedido;
            cont_d   = '0;
          end else begin
            cont_d = cont_q + 1'b1;
          end
        end
        default: begin
          estado_d = drone_pkg::OCIOSO;
          cont_d   = '0;
        end
      endcase
    end

    assign saida_w[g]  = (estado_q == drone_pkg::ATIVO) ? codigo_q : drone_pkg::CODIGO_PARADO;
    assign estado_w[g] = estado_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      confirma_q <= 1'b0;
    end else begin
      confirma_q <= filtrado[4];
    end
  end

  assign controle_vertical   = saida_w[0];
  assign controle_horizontal = saida_w[1];
  assign confirma            = confirma_q;
  assign db_estado           = {estado_w[0], estado_w[1]};

endmodule

// File: tb/tb_controle_drone_entrada.sv
// Bench for controle_drone_entrada: directed scenarios plus random button
// activity, compared every cycle against a behavioural reference model.
module tb_controle_drone_entrada;

  localparam int DB = 4;
  localparam int RP = 200;
  localparam int PS = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] btn;
  logic [1:0] controle_vertical, controle_horizontal;
  logic       confirma;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_fail   = 0;

  controle_drone_entrada #(.DEBOUNCE(DB), .REPETE(RP), .PAUSA(PS)) dut (
    .clock              (clock),
    .reset              (reset),
    .botao_cima         (btn[0]),
    .botao_baixo        (btn[1]),
    .botao_frente       (btn[2]),
    .botao_tras         (btn[3]),
    .botao_confirma     (btn[4]),
    .controle_vertical  (controle_vertical),
    .controle_horizontal(controle_horizontal),
    .confirma           (confirma),
    .db_estado          (db_estado)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Filter: level follows the raw input once the D+1 samples that reached the
  // filter (raw taken two edges earlier and before) all disagree with it.
  // Axis: a held request is shown for RP edges out of every RP+PS, counted
  // from the edge it started (or from a direction swap while shown).
  logic [DB+2:0] hist_m [5];
  logic [4:0]    filt_m;
  int            edge_n;
  logic          eng_m [2];
  int            t0_m  [2];
  logic [1:0]    out_m [2];
  logic [1:0]    st_m  [2];
  logic          conf_m;

  int n_v_on, n_h_on, n_h_zero;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] req_of(input logic pos, input logic neg);
    if (pos && !neg) return 2'b01;
    if (neg && !pos) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 5; b++) hist_m[b] = '0;
    filt_m = '0;
    conf_m = 1'b0;
    for (int a = 0; a < 2; a++) begin
      eng_m[a] = 1'b0; t0_m[a] = 0; out_m[a] = 2'b00; st_m[a] = 2'b00;
    end
  endtask

  task automatic upd_axis(input int a, input logic [1:0] req);
    if (req == 2'b00) begin
      eng_m[a] = 1'b0;
      out_m[a] = 2'b00;
    end else if (!eng_m[a] || (out_m[a] != 2'b00 && req != out_m[a])) begin
      eng_m[a] = 1'b1;
      t0_m[a]  = edge_n;
      out_m[a] = req;
    end else begin
      out_m[a] = (((edge_n - t0_m[a]) % (RP + PS)) < RP) ? req : 2'b00;
    end
    st_m[a] = (out_m[a] != 2'b00) ? 2'b01 : (eng_m[a] ? 2'b10 : 2'b00);
  endtask

  task automatic step();
    logic [1:0]  rv, rh;
    logic [DB:0] win;
    @(posedge clock);
    #1;
    edge_n++;
    if (reset) begin
      model_reset();
    end else begin
      rv = req_of(filt_m[0], filt_m[1]);
      rh = req_of(filt_m[2], filt_m[3]);
      upd_axis(0, rv);
      upd_axis(1, rh);
      conf_m = filt_m[4];
      for (int b = 0; b < 5; b++) begin
        hist_m[b] = {hist_m[b][DB+1:0], btn[b]};
        win = hist_m[b][DB+2:2];
        if ((!filt_m[b] && win == '1) || (filt_m[b] && win == '0)) filt_m[b] = ~filt_m[b];
      end
    end
    check("vertical",   controle_vertical,   out_m[0]);
    check("horizontal", controle_horizontal, out_m[1]);
    check("confirma",   confirma,            conf_m);
    check("db_estado",  db_estado,           {st_m[0], st_m[1]});
    if (controle_vertical != 2'b00) n_v_on++;
    if (controle_horizontal != 2'b00) n_h_on++;
    else n_h_zero++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input logic [4:0] v);
    @(negedge clock);
    btn = v;
  endtask

  task automatic set_reset(input logic r);
    @(negedge clock);
    reset = r;
  endtask

  // Steps until controle_vertical equals val; returns steps taken (limit+1 on timeout).
  task automatic wait_vert(input logic [1:0] val, input int limit, output int n);
    n = 0;
    while (n <= limit) begin
      step();
      n++;
      if (controle_vertical == val) return;
    end
  endtask

  initial begin
    int n;
    edge_n = 0;
    model_reset();
    // Test 1: reset held with cima, frente and confirma pressed.
    reset = 1'b1;
    btn   = 5'b10101;
    #1;
    check("rst_async_v", controle_vertical, 0);
    check("rst_async_db", db_estado, 0);
    run(10);
    set_reset(1'b0);
    wait_vert(2'b01, 20, n);
    check("lat_release", n - 1, 3 + DB);
    check("lat_horiz", controle_horizontal, 2'b01);
    check("lat_conf", confirma, 1);
    drive(5'b00000);
    run(20);

    // Test 2: 3-cycle glitch then a 5-cycle press on frente.
    n_h_on = 0;
    drive(5'b00100); run(3);
    drive(5'b00000); run(20);
    check("glitch_h", n_h_on, 0);
    drive(5'b00100); run(5);
    drive(5'b00000); run(25);
    check("pulse5_h", n_h_on, 5);

    // Test 3: cima held for 500 cycles.
    n_v_on = 0;
    drive(5'b00001); run(500);
    drive(5'b00000); run(20);
    check("hold500_on", n_v_on, 500 - 2 * PS);

    // Test 4: baixo held, then cima too, then baixo released.
    drive(5'b00010); run(30);
    check("baixo_v", controle_vertical, 2'b10);
    drive(5'b00011); run(20);
    check("both_v", controle_vertical, 2'b00);
    check("both_st", db_estado[3:2], 2'b00);
    drive(5'b00001);
    wait_vert(2'b01, 20, n);
    check("lat_cima", n - 1, 3 + DB);
    drive(5'b00000); run(20);

    // Test 5: frente swapped to tras on the same negedge.
    drive(5'b00100); run(50);
    drive(5'b01000);
    n_h_zero = 0;
    run(20);
    check("swap_nozero", n_h_zero, 0);
    check("swap_code", controle_horizontal, 2'b10);
    n = 20;
    while (controle_horizontal != 2'b00 && n < 400) begin
      step();
      n++;
    end
    check("swap_gap", n, 3 + DB + RP + 1);
    drive(5'b00000); run(30);

    // Test 6: asynchronous reset during a vertical pause with confirm held.
    drive(5'b00001); run(200);
    drive(5'b10001); run(15);
    check("pause_st", db_estado[3:2], 2'b10);
    check("pause_conf", confirma, 1);
    set_reset(1'b1);
    #1;
    check("arst_v", controle_vertical, 0);
    check("arst_conf", confirma, 0);
    check("arst_db", db_estado, 0);
    run(3);
    btn = 5'b00000;
    set_reset(1'b0);
    run(20);

    // Random activity, including glitches and short resets.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        set_reset(1'b1);
        #1;
        check("rnd_arst", {controle_vertical, controle_horizontal, confirma}, 0);
        run($urandom_range(1, 3));
        set_reset(1'b0);
      end else begin
        drive(5'($urandom_range(0, 31)));
        if ($urandom_range(0, 1) == 0) run($urandom_range(1, 12));
        else run($urandom_range(20, 480));
      end
    end
    drive(5'b00000);
    run(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
